// File: rtl/axis_arb_pkg.sv
// ============================================================================
//  Module      : axis_arb_pkg
//  Description : Shared state encoding and default sizing for the AXI-Stream
//                round-robin arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_arb_pkg;

    localparam int c_def_num_ports = 4;
    localparam int c_def_data_w    = 8;

    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector; finds the first set
//                request strictly after i_last_grant, wrapping to port 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter  int NUM_PORTS = 4,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [IDX_W-1:0]     i_last_grant,
    output logic                 o_found,
    output logic [IDX_W-1:0]     o_next_idx
);

    logic             w_found_lo;
    logic             w_found_hi;
    logic [IDX_W-1:0] w_idx_lo;
    logic [IDX_W-1:0] w_idx_hi;

    // Descending scan: the last hit written is the lowest index. The "hi"
    // search only considers ports above the last grant; "lo" is the wrap.
    always_comb begin
        w_found_lo = 1'b0;
        w_found_hi = 1'b0;
        w_idx_lo   = '0;
        w_idx_hi   = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_found_lo = 1'b1;
                w_idx_lo   = IDX_W'(i);
                if (i > int'(i_last_grant)) begin
                    w_found_hi = 1'b1;
                    w_idx_hi   = IDX_W'(i);
                end
            end
        end
    end

    assign o_found    = w_found_lo;
    assign o_next_idx = w_found_hi ? w_idx_hi : w_idx_lo;

endmodule

`default_nettype wire

// File: rtl/axis_rr_arbiter.sv
// ============================================================================
//  Module      : axis_rr_arbiter
//  Description : Packet-level round-robin merge of NUM_PORTS AXI-Stream
//                slaves onto one master stream, with a bubble between packets.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_PORTS = c_def_num_ports,
    parameter  int DATA_W    = c_def_data_w,
    localparam int IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [NUM_PORTS-1:0]        s_axis_tvalid,
    input  logic [NUM_PORTS*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]        s_axis_tkeep,
    input  logic [NUM_PORTS-1:0]        s_axis_tlast,
    output logic [NUM_PORTS-1:0]        s_axis_tready,
    output logic                        m_axis_tvalid,
    output logic [DATA_W-1:0]           m_axis_tdata,
    output logic                        m_axis_tkeep,
    output logic                        m_axis_tlast,
    input  logic                        m_axis_tready,
    output logic [IDX_W-1:0]            grant_id,
    output logic                        busy
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDX_W-1:0] r_grant_id;
    logic [IDX_W-1:0] w_grant_nxt;
    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] w_last_nxt;
    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic             w_busy;
    logic             w_beat;
    logic [DATA_W-1:0] w_tdata_arr [NUM_PORTS];

    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
        assign w_tdata_arr[gi] = s_axis_tdata[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .i_req        (s_axis_tvalid),
        .i_last_grant (r_last_grant),
        .o_found      (w_found),
        .o_next_idx   (w_pick)
    );

    // last_grant resets to the top port so the first search begins at port 0
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state      <= ARB_IDLE;
            r_grant_id   <= '0;
            r_last_grant <= IDX_W'(NUM_PORTS - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant_id   <= w_grant_nxt;
            r_last_grant <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant_id;
        w_last_nxt    = r_last_grant;
        w_busy        = (r_state == ARB_BUSY);
        s_axis_tready = '0;

        // Pure mux path: the granted port drives the master side directly
        m_axis_tvalid = w_busy & s_axis_tvalid[r_grant_id];
        m_axis_tdata  = w_tdata_arr[r_grant_id];
        m_axis_tkeep  = s_axis_tkeep[r_grant_id];
        m_axis_tlast  = s_axis_tlast[r_grant_id];
        if (w_busy) begin
            s_axis_tready[r_grant_id] = m_axis_tready;
        end
        w_beat = m_axis_tvalid & m_axis_tready;

        case (r_state)
            ARB_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (w_beat && m_axis_tlast) begin
                    w_last_nxt  = r_grant_id;
                    w_state_nxt = ARB_IDLE;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    assign grant_id = r_grant_id;
    assign busy     = w_busy;

endmodule

`default_nettype wire
